id_scoreboard_ctrl: RTL
=======================

Name: id_scoreboard_ctrl

Overview:
- Parametrised successor to the ID-stage handshake and hazard controller.
- Replaces fixed two-stage rd comparison with a per-register pending-write scoreboard, so any number of in-flight writers are tracked.
- Supports multiple writeback ports, multi-source instructions, WAW saturation stall, pipeline flush and a busy indicator.
- Sits between IF (IF_valid) and EX (EX_ready). Drives ID valid/ready.

Parameters:
- GW, 2, register-group field width; groups 0..2^GW-1.
- IDX_W, 5, register index width.
- NSRC, 3, source operands per instruction.
- NWB, 2, writeback (release) ports.
- CNT_W, 2, pending counter width; max outstanding writes per register = 2^CNT_W-1.
- GRP_INVALID, 0, group code meaning "no register".
- GRP_R, 1, integer group; index 0 hardwired zero, never tracked.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- IF_valid  in  1  IF has an instruction.
- EX_ready  in  1  EX accepts.
- valid  out  1  ID holds a valid instruction for EX.
- ready  out  1  ID accepts from IF this cycle.
- src_group  in  NSRC*GW  packed source groups; source k at bits [k*GW +: GW].
- src_index  in  NSRC*IDX_W  packed source indices.
- rd_group  in  GW  destination group of the incoming instruction.
- rd_index  in  IDX_W  destination index of the incoming instruction.
- wb_en  in  NWB  writeback release strobes.
- wb_group  in  NWB*GW  packed release groups.
- wb_index  in  NWB*IDX_W  packed release indices.
- flush  in  1  squash in-flight state.
- busy  out  1  any counter nonzero.
- stall  out  1  IF_valid & !ready (hazard or backpressure).

Behaviour:
- Tracked register: group != GRP_INVALID and not (group == GRP_R and index == 0). Untracked sources never conflict. Untracked rd or wb entries never modify counters.
- Storage: one CNT_W counter per (group, index), groups 1..2^GW-1.
- All counters reset to 0 asynchronously. valid=0, busy=0 while rst low.
- conflict: any tracked source whose counter is nonzero. Evaluated on registered counters only. A same-cycle wb to that register does NOT clear the conflict until the next cycle.
- sat: rd is tracked and its counter == 2^CNT_W-1.
- ready = (EX_ready | !valid) & !conflict & !sat & !flush.
- issue = IF_valid & ready.
- valid next state:
  - flush -> 0.
  - else issue -> 1.
  - else EX_ready -> 0.
  - else hold.
- Counter update per register each cycle: next = cnt + inc - dec.
  - inc = issue & (rd matches register).
  - dec = number of wb ports with wb_en and matching group/index.
  - Result clamps at 0 (release of an idle register is ignored).
  - Increment is never applied when saturated, because sat blocks issue.
- Simultaneous issue and wb on the same register: net change = 1 - dec.
- Two wb ports naming the same register in one cycle: decrement by 2, clamped at 0.
- flush: synchronous, highest priority. All counters -> 0 and valid -> 0 at the next edge. Issue and wb in that cycle are discarded.
- busy: OR of all counters, registered view (same cycle as counters).
- stall is combinational.
- Latency:
  - A released register is readable by a waiting instruction one cycle after the wb_en cycle.
  - Issue-to-valid is 1 cycle.
- Reset asserted mid-operation: counters and valid clear immediately (asynchronously). First issue is possible in the first cycle after rst deasserts.

Test Plan:
- Reset then IF_valid=1, EX_ready=1, rd=(1,5), srcs invalid -> ready=1; after the edge valid=1, busy=1, counter(1,5)=1.
- Next instruction src0=(1,5), no wb -> ready=0, stall=1. Assert wb_en[0] on (1,5) -> ready=1 only in the following cycle; instruction then issues.
- Source (1,0) and rd=(1,0) repeated 10 times -> never stalls, busy stays 0.
- Issue rd=(2,3) three times with no wb -> counter=3. Fourth issue to (2,3) blocked (sat). Both wb ports release (2,3) in one cycle -> counter=1; 4th issue proceeds next cycle.
- Pending counters on (1,5) and (2,3), EX_ready=0, valid=1; pulse flush with IF_valid=1 -> ready=0 that cycle; next cycle valid=0, busy=0, all counters 0.
- Drop rst low asynchronously mid-stall -> valid and busy fall without a clock edge. After release, previously conflicting src issues immediately.

Source files
------------

// File: rtl/id_scoreboard_ctrl.sv
// ID-stage handshake and hazard controller backed by a per-register pending-write
// scoreboard; tracks any number of in-flight writers up to a saturating count.
module id_scoreboard_ctrl #(
    parameter int          GW          = 2,
    parameter int          IDX_W       = 5,
    parameter int          NSRC        = 3,
    parameter int          NWB         = 2,
    parameter int          CNT_W       = 2,
    parameter int unsigned GRP_INVALID = 0,
    parameter int unsigned GRP_R       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   IF_valid,
    input  logic                   EX_ready,
    output logic                   valid,
    output logic                   ready,
    input  logic [NSRC*GW-1:0]     src_group,
    input  logic [NSRC*IDX_W-1:0]  src_index,
    input  logic [GW-1:0]          rd_group,
    input  logic [IDX_W-1:0]       rd_index,
    input  logic [NWB-1:0]         wb_en,
    input  logic [NWB*GW-1:0]      wb_group,
    input  logic [NWB*IDX_W-1:0]   wb_index,
    input  logic                   flush,
    output logic                   busy,
    output logic                   stall
);
    localparam int               RW        = GW + IDX_W;
    localparam int               NREG      = 1 << RW;
    localparam int               SW        = CNT_W + $clog2(NWB + 1) + 1;
    localparam logic [GW-1:0]    GRP_INV_C = GW'(GRP_INVALID);
    localparam logic [GW-1:0]    GRP_R_C   = GW'(GRP_R);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    function automatic logic is_tracked(input logic [GW-1:0] g, input logic [IDX_W-1:0] i);
        return (g != GRP_INV_C) && !((g == GRP_R_C) && (i == {IDX_W{1'b0}}));
    endfunction

    // Group-0 entries exist only to keep the flat {group,index} addressing simple; they never move.
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             conflict_s, sat_s, ready_s, issue_s, rd_trk_s;
    logic [RW-1:0]    rd_flat_s;
    logic [RW-1:0]    wb_flat_s [NWB];
    logic [NWB-1:0]   wb_trk_s;

    // Hazard detection on registered counters and the resulting handshake.
    always_comb begin
        rd_flat_s  = {rd_group, rd_index};
        rd_trk_s   = is_tracked(rd_group, rd_index);
        conflict_s = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            conflict_s = conflict_s
                | (is_tracked(src_group[k*GW +: GW], src_index[k*IDX_W +: IDX_W])
                   && (cnt_q[{src_group[k*GW +: GW], src_index[k*IDX_W +: IDX_W]}] != {CNT_W{1'b0}}));
        end
        sat_s   = rd_trk_s && (cnt_q[rd_flat_s] == CNT_MAX);
        ready_s = (EX_ready | ~valid_q) & ~conflict_s & ~sat_s & ~flush;
        issue_s = IF_valid & ready_s;
    end

    // Flatten writeback ports into scoreboard addresses.
    always_comb begin
        for (int p = 0; p < NWB; p++) begin
            wb_flat_s[p] = {wb_group[p*GW +: GW], wb_index[p*IDX_W +: IDX_W]};
            wb_trk_s[p]  = wb_en[p] & is_tracked(wb_group[p*GW +: GW], wb_index[p*IDX_W +: IDX_W]);
        end
    end

    // Next counter values: +issue, -releases, floor at zero; flush clears everything.
    always_comb begin
        logic          inc_v;
        logic [SW-1:0] dec_v;
        logic [SW-1:0] sum_v;
        inc_v  = 1'b0;
        dec_v  = {SW{1'b0}};
        sum_v  = {SW{1'b0}};
        busy_d = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc_v = issue_s && rd_trk_s && (rd_flat_s == RW'(r));
            dec_v = {SW{1'b0}};
            for (int p = 0; p < NWB; p++) begin
                if (wb_trk_s[p] && (wb_flat_s[p] == RW'(r))) begin
                    dec_v = dec_v + SW'(1);
                end else begin
                    dec_v = dec_v;
                end
            end
            sum_v = SW'(cnt_q[r]) + SW'(inc_v);
            if (flush) begin
                cnt_d[r] = {CNT_W{1'b0}};
            end else if (sum_v > dec_v) begin
                cnt_d[r] = CNT_W'(sum_v - dec_v);
            end else begin
                cnt_d[r] = {CNT_W{1'b0}};
            end
            busy_d = busy_d | (cnt_d[r] != {CNT_W{1'b0}});
        end
    end

    // ID valid flag: flush beats issue beats EX consumption.
    always_comb begin
        if (flush) begin
            valid_d = 1'b0;
        end else if (issue_s) begin
            valid_d = 1'b1;
        end else if (EX_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= {CNT_W{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign valid = valid_q;
    assign busy  = busy_q;
    assign ready = ready_s;
    assign stall = IF_valid & ~ready_s;

endmodule
